// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache miss path and the dcache fill/writeback path.
// Optional instruction-fetch starvation guard: define STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_e;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_e;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_e     state_q, state_d;
    ram_state_e ram_state;
    logic       d_req;
    logic       i_starved;

    assign ram_state = ram_state_e'(ramstate);
    assign d_req     = dREN | dWEN;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Counts data completions that overtook a waiting fetch; saturates at 15.
    always_comb begin
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (!iREN) starve_d = '0;
            end
            DGRANT: begin
                if (d_req && iREN && ram_state == RAM_ACCESS && starve_q != 4'hF)
                    starve_d = starve_q + 4'd1;
            end
            IGRANT: begin
                if (iREN && ram_state == RAM_ACCESS) starve_d = '0;
            end
            default: ;
        endcase
    end

    assign i_starved = iREN && (starve_q >= LIMIT);
`else
    assign i_starved = 1'b0;
`endif

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = d_req;
        iload    = '0;
        dload    = '0;

        case (state_q)
            IDLE: begin
                if (i_starved)  state_d = IGRANT;
                else if (d_req) state_d = DGRANT;
                else if (iREN)  state_d = IGRANT;
            end

            DGRANT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_state == RAM_ACCESS) begin
                        dwait   = 1'b0;
                        dload   = ramload;
                        state_d = IDLE;
                    end else if (ram_state == RAM_ERROR) begin
                        state_d = IDLE;
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_state == RAM_ACCESS) begin
                        iwait   = 1'b0;
                        iload   = ramload;
                        state_d = IDLE;
                    end else if (ram_state == RAM_ERROR) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a per-cycle vector table plus directed multi-cycle sequences.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  rs;
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_dwait;
        logic [31:0] e_dload;
        logic        e_rren;
        logic        e_rwen;
        logic [31:0] e_raddr;
        logic [31:0] e_rstore;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                                input logic [1:0] rs, input logic eiw, input logic [31:0] eil,
                                input logic edw, input logic [31:0] edl, input logic err,
                                input logic erw, input logic [31:0] era, input logic [31:0] ers);
        vec_t v;
        v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da; v.dstore = ds;
        v.ramload = rl; v.rs = rs; v.e_iwait = eiw; v.e_iload = eil; v.e_dwait = edw;
        v.e_dload = edl; v.e_rren = err; v.e_rwen = erw; v.e_raddr = era; v.e_rstore = ers;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                         input logic [1:0] rs);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramload = rl; ramstate = rs;
    endtask

    // Advance to the next falling edge, apply inputs, and let combinational outputs settle.
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                         input logic [1:0] rs);
        @(negedge CLK);
        drive(ir, ia, dr, dw, da, ds, rl, rs);
        #1;
    endtask

    vec_t vecs[16];
    int   dcompl, icompl, budget;

    initial begin
        // Each row is one clock cycle; the arbiter state carries over from the row before.
        vecs[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, FREE,            1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h40, 0, 0, 0, 0, 0, FREE,            1, 0, 0, 0, 1, 0, 32'h40, 0);
        vecs[2]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h2108_0001, ACC, 0, 32'h2108_0001, 0, 0, 1, 0, 32'h40, 0);
        vecs[3]  = mk(1, 32'h44, 1, 0, 32'h100, 0, 0, FREE,      1, 0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 32'h44, 1, 0, 32'h100, 0, 0, BUSY,      1, 0, 1, 0, 1, 0, 32'h100, 0);
        vecs[5]  = mk(1, 32'h44, 1, 0, 32'h100, 0, 32'hCAFE_0000, ACC,
                      1, 0, 0, 32'hCAFE_0000, 1, 0, 32'h100, 0);
        vecs[6]  = mk(1, 32'h44, 0, 0, 0, 0, 0, FREE,            1, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 32'h44, 0, 0, 0, 0, 32'h1111_2222, ACC, 0, 32'h1111_2222, 0, 0, 1, 0, 32'h44, 0);
        vecs[8]  = mk(0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, FREE, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, BUSY, 0, 0, 1, 0, 0, 1, 32'h200, 32'hDEAD_BEEF);
        vecs[10] = vecs[9];
        vecs[11] = vecs[9];
        vecs[12] = mk(0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, ACC,  0, 0, 0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF);
        vecs[13] = mk(0, 0, 1, 1, 32'h300, 32'h1234_5678, 0, FREE, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 1, 32'h300, 32'h1234_5678, 0, ACC,  0, 0, 0, 0, 0, 1, 32'h300, 32'h1234_5678);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, FREE,                 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with a pending fetch: no strobes, fetch stalled.
        nRST = 1'b0;
        drive(1, 32'h40, 0, 0, 0, 0, 0, FREE);
        #2;
        check("reset_ramREN", 32'(ramREN), 32'd0);
        check("reset_iwait", 32'(iwait), 32'd1);
        check("reset_ramaddr", ramaddr, 32'd0);
        check("reset_dwait", 32'(dwait), 32'd0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, FREE);
        nRST = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen, vecs[i].daddr,
                  vecs[i].dstore, vecs[i].ramload, vecs[i].rs);
            check($sformatf("v%0d_iwait", i), 32'(iwait), 32'(vecs[i].e_iwait));
            check($sformatf("v%0d_iload", i), iload, vecs[i].e_iload);
            check($sformatf("v%0d_dwait", i), 32'(dwait), 32'(vecs[i].e_dwait));
            check($sformatf("v%0d_dload", i), dload, vecs[i].e_dload);
            check($sformatf("v%0d_ramREN", i), 32'(ramREN), 32'(vecs[i].e_rren));
            check($sformatf("v%0d_ramWEN", i), 32'(ramWEN), 32'(vecs[i].e_rwen));
            check($sformatf("v%0d_ramaddr", i), ramaddr, vecs[i].e_raddr);
            check($sformatf("v%0d_ramstore", i), ramstore, vecs[i].e_rstore);
        end

        // RAM error during an instruction grant: no completion, back to IDLE, then retried.
        cycle(1, 32'h80, 0, 0, 0, 0, 0, FREE);
        check("err_idle_ramREN", 32'(ramREN), 32'd0);
        cycle(1, 32'h80, 0, 0, 0, 0, 32'h9999_9999, ERR);
        check("err_grant_iwait", 32'(iwait), 32'd1);
        check("err_grant_iload", iload, 32'd0);
        check("err_grant_ramREN", 32'(ramREN), 32'd1);
        cycle(1, 32'h80, 0, 0, 0, 0, 0, FREE);
        check("err_back_idle_ramREN", 32'(ramREN), 32'd0);
        check("err_back_idle_iwait", 32'(iwait), 32'd1);
        cycle(1, 32'h80, 0, 0, 0, 0, 32'h0000_0077, ACC);
        check("err_retry_ramaddr", ramaddr, 32'h80);
        check("err_retry_iwait", 32'(iwait), 32'd0);
        check("err_retry_iload", iload, 32'h77);

        // Data request withdrawn mid-grant, with a fetch waiting behind it.
        cycle(1, 32'hC0, 1, 0, 32'h140, 0, 0, FREE);
        check("drop_idle_dwait", 32'(dwait), 32'd1);
        cycle(1, 32'hC0, 1, 0, 32'h140, 0, 0, BUSY);
        check("drop_grant_ramREN", 32'(ramREN), 32'd1);
        check("drop_grant_ramaddr", ramaddr, 32'h140);
        cycle(1, 32'hC0, 0, 0, 32'h140, 0, 32'h5555_5555, ACC);
        check("drop_ramREN", 32'(ramREN), 32'd0);
        check("drop_dwait", 32'(dwait), 32'd0);
        check("drop_dload", dload, 32'd0);
        check("drop_iwait", 32'(iwait), 32'd1);
        cycle(1, 32'hC0, 0, 0, 0, 0, 0, FREE);
        check("drop_idle_ramREN", 32'(ramREN), 32'd0);
        cycle(1, 32'hC0, 0, 0, 0, 0, 32'h0000_00C0, ACC);
        check("drop_igrant_ramaddr", ramaddr, 32'hC0);
        check("drop_igrant_iwait", 32'(iwait), 32'd0);
        check("drop_igrant_iload", iload, 32'hC0);

        // Fetch held against back-to-back data reads that all complete in one cycle.
        cycle(0, 0, 0, 0, 0, 0, 0, FREE);
        dcompl = 0;
        icompl = 0;
`ifdef STARVE_GUARD_EN
        budget = 30;
        while (icompl == 0 && budget > 0) begin
            cycle(1, 32'h1C0, 1, 0, 32'h180, 0, 32'hAAAA_0000, ACC);
            if (dREN && !dwait) dcompl++;
            if (iREN && !iwait) icompl++;
            budget--;
        end
        check("starve_icompl", 32'(icompl), 32'd1);
        check("starve_dcompl_before_fetch", 32'(dcompl), 32'd4);
`else
        for (int k = 0; k < 20; k++) begin
            cycle(1, 32'h1C0, 1, 0, 32'h180, 0, 32'hAAAA_0000, ACC);
            if (dREN && !dwait) dcompl++;
            if (iREN && !iwait) icompl++;
        end
        check("strict_icompl", 32'(icompl), 32'd0);
        check("strict_dcompl", 32'(dcompl), 32'd10);
`endif

        // Reset asserted in the middle of a grant kills the strobes immediately.
        cycle(0, 0, 0, 0, 0, 0, 0, FREE);
        cycle(1, 32'h300, 0, 0, 0, 0, 0, FREE);
        cycle(1, 32'h300, 0, 0, 0, 0, 0, BUSY);
        check("rstmid_pre_ramREN", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        check("rstmid_ramREN", 32'(ramREN), 32'd0);
        check("rstmid_ramaddr", ramaddr, 32'd0);
        check("rstmid_iwait", 32'(iwait), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
